instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk and reset (reset asserted when low).
REQ-002 The ports SHALL be, one per line, as follows.
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- Address  out  32  instruction-memory byte address (= PC)
- Instruction  in  32  instruction-memory read data, combinational from Address
- stall  in  1  hold PC and IF/ID register (load-use hazard)
- id_redirect  in  1  jump/JR resolved in ID
- id_target  in  32  ID redirect target
- ex_redirect  in  1  taken branch resolved in EX
- ex_target  in  32  EX redirect target
- if_id_instr  out  32  registered instruction to ID
- if_id_pc_plus4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  IF/ID slot holds a real instruction
- irq  in  1  external interrupt (IF_EXCEPTION_EN only)
- epc  out  32  saved return PC (IF_EXCEPTION_EN only)

Function
REQ-003 Address SHALL equal the PC register combinationally, with zero added latency.
REQ-004 Next-PC priority SHALL be: reset > irq (when enabled) > ex_redirect > id_redirect > stall > PC+4.
REQ-005 ex_redirect SHALL load PC with ex_target, override stall, and flush IF/ID: instr=0x00000000, valid=0, pc_plus4 unchanged.
REQ-006 id_redirect with stall=0 SHALL load PC with id_target and flush IF/ID as in REQ-005.
REQ-007 id_redirect with stall=1 SHALL be ignored, because ID re-presents the redirect after the stall.
REQ-008 Simultaneous ex_redirect and id_redirect SHALL take ex_target, since EX holds the older instruction.
REQ-009 Redirect targets SHALL have bits [1:0] forced to 0 before they are loaded into PC.
REQ-010 With stall=1 and no EX redirect, PC and all IF/ID outputs SHALL hold.
REQ-011 Otherwise, on each rising edge:
- PC <= PC+4;
- if_id_instr <= Instruction;
- if_id_pc_plus4 <= PC+4;
- if_id_valid <= 1.
REQ-012 PC+4 SHALL be 32-bit modulo: 0xFFFFFFFC advances to 0x00000000.
REQ-013 The fetch-to-ID latency SHALL be exactly one cycle: the instruction at Address in cycle N appears on if_id_instr in cycle N+1.

Reset
REQ-014 While reset is low, the following SHALL hold immediately, independent of clk:
- PC=0x00000000;
- if_id_instr=0x00000000;
- if_id_pc_plus4=0x00000000;
- if_id_valid=0;
- epc=0x00000000.
REQ-015 Reset asserted mid-stall or mid-redirect SHALL discard all pending state.
REQ-016 On the first rising edge after reset deasserts, the instruction from 0x00000000 SHALL be captured into IF/ID.

Configuration
REQ-017 Macro IF_EXCEPTION_EN SHALL control the interrupt feature.
REQ-018 With IF_EXCEPTION_EN defined, irq=1 on a rising edge SHALL:
- load PC with 0x80000004;
- flush IF/ID;
- set epc to the address of the oldest unretired fetch: Address when IF/ID is invalid, else if_id_pc_plus4-4.
REQ-019 With IF_EXCEPTION_EN defined, irq SHALL override stall and both redirects.
REQ-020 Without IF_EXCEPTION_EN, the irq and epc ports SHALL be absent, and no exception logic SHALL exist.

Verification
REQ-021 Reset, release, then 4 cycles with no stall -> Address 0x0,0x4,0x8,0xC; if_id_instr follows one cycle behind with valid=1.
REQ-022 stall=1 for 2 cycles at PC=0x10 -> Address stays 0x10 and IF/ID holds the 0xC instruction; the cycle after release captures the 0x10 instruction.
REQ-023 id_redirect=1 with id_target=0x0000000E at PC=0x8 -> next Address=0x0000000C and if_id_valid=0 for one cycle.
REQ-024 ex_redirect (target 0x40), id_redirect (target 0x80) and stall=1 all asserted together -> next Address=0x40 and IF/ID flushed.
REQ-025 PC=0xFFFFFFFC with no stall -> next Address=0x00000000.
REQ-026 With IF_EXCEPTION_EN defined: irq=1 while stall=1 and IF/ID holds PC 0x24 -> Address=0x80000004, epc=0x24, if_id_valid=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Purpose: fetch-stage bus bundle -- instruction-memory port, hazard/redirect
//          controls from ID/EX, and the IF/ID pipeline register outputs.
// Signals:
//   Address        fetch byte address (PC)          master -> slave
//   Instruction    memory read data for Address     slave  -> master
//   stall          hold PC and IF/ID                slave  -> master
//   id_redirect/id_target, ex_redirect/ex_target    slave  -> master
//   if_id_instr, if_id_pc_plus4, if_id_valid        master -> slave
//   irq / epc      interrupt request / saved PC (only with IF_EXCEPTION_EN)
// Macro: IF_EXCEPTION_EN adds the irq and epc signals.
interface instruction_fetch_if;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef IF_EXCEPTION_EN
  logic        irq;
  logic [31:0] epc;
`endif

  // Fetch unit side.
  modport master (
    output Address,
    input  Instruction,
    input  stall,
    input  id_redirect,
    input  id_target,
    input  ex_redirect,
    input  ex_target,
    output if_id_instr,
    output if_id_pc_plus4,
    output if_id_valid
`ifdef IF_EXCEPTION_EN
   ,input  irq,
    output epc
`endif
  );

  // Memory / pipeline side.
  modport slave (
    input  Address,
    output Instruction,
    output stall,
    output id_redirect,
    output id_target,
    output ex_redirect,
    output ex_target,
    input  if_id_instr,
    input  if_id_pc_plus4,
    input  if_id_valid
`ifdef IF_EXCEPTION_EN
   ,output irq,
    input  epc
`endif
  );
endinterface

// File: rtl/instruction_fetch.sv
// Purpose: instruction fetch stage. Holds the PC, drives the instruction-memory
//          address and captures the fetched word into the IF/ID register.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    instruction_fetch_if.master (Address/Instruction, stall,
//          ID/EX redirects, IF/ID outputs, optional irq/epc)
// Macro: IF_EXCEPTION_EN enables the external interrupt (irq -> vector
//        0x80000004, epc capture). Without it no exception logic exists.
module instruction_fetch (
  input  logic               clk,
  input  logic               reset,
  instruction_fetch_if.master bus
);
  localparam int unsigned XLEN = 32;
`ifdef IF_EXCEPTION_EN
  localparam logic [XLEN-1:0] IRQ_VECTOR = 32'h8000_0004;
`endif

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_plus4;
`ifdef IF_EXCEPTION_EN
  logic [XLEN-1:0] epc_q, epc_d;
`endif

  // Wraps naturally at 32 bits.
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-state selection; the if-chain order encodes redirect priority.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
`ifdef IF_EXCEPTION_EN
    epc_d   = epc_q;
    if (bus.irq) begin
      pc_d    = IRQ_VECTOR;
      instr_d = '0;
      valid_d = 1'b0;
      // Oldest unretired fetch: the IF/ID instruction if present, else the PC.
      epc_d   = valid_q ? (pc4_q - XLEN'(4)) : pc_q;
    end else
`endif
    if (bus.ex_redirect) begin
      // EX holds the older instruction, so it beats ID and stall.
      pc_d    = {bus.ex_target[XLEN-1:2], 2'b00};
      instr_d = '0;
      valid_d = 1'b0;
    end else if (bus.id_redirect && !bus.stall) begin
      // A stalled ID re-presents its redirect, so only act when not stalled.
      pc_d    = {bus.id_target[XLEN-1:2], 2'b00};
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d    = pc_plus4;
      instr_d = bus.Instruction;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
`ifdef IF_EXCEPTION_EN
      epc_q   <= '0;
`endif
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
`ifdef IF_EXCEPTION_EN
      epc_q   <= epc_d;
`endif
    end
  end

  assign bus.Address        = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc4_q;
  assign bus.if_id_valid    = valid_q;
`ifdef IF_EXCEPTION_EN
  assign bus.epc            = epc_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: the stimulus process pushes the
// expected post-edge state, a monitor pops and compares after each edge
// (or after an explicit asynchronous sample point).
module tb_instruction_fetch;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] epc;
  } exp_t;

  logic clk;
  logic reset;
  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory model: data is a simple function of the address.
  assign bus.Instruction = bus.Address ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  event sample_ev;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   step   = 0;

  function automatic exp_t mk(logic [31:0] a, logic [31:0] i, logic [31:0] p,
                              logic v, logic [31:0] e);
    exp_t r;
    r.addr = a; r.instr = i; r.pc4 = p; r.valid = v; r.epc = e;
    return r;
  endfunction

  // Monitor: one expectation per sample point.
  initial begin
    exp_t e;
    logic [31:0] act_epc;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step++;
`ifdef IF_EXCEPTION_EN
        act_epc = bus.epc;
`else
        act_epc = e.epc;
`endif
        n_cmp++;
        if (bus.Address !== e.addr || bus.if_id_instr !== e.instr ||
            bus.if_id_pc_plus4 !== e.pc4 || bus.if_id_valid !== e.valid ||
            act_epc !== e.epc) begin
          n_fail++;
          $display("FAIL step%0d: got A=%h instr=%h pc4=%h v=%b epc=%h, want A=%h instr=%h pc4=%h v=%b epc=%h",
                   step, bus.Address, bus.if_id_instr, bus.if_id_pc_plus4, bus.if_id_valid, act_epc,
                   e.addr, e.instr, e.pc4, e.valid, e.epc);
        end
      end
    end
  end

  // Queue the expected state after the next rising edge, then advance.
  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic idr, input logic [31:0] idt,
                       input logic exr, input logic [31:0] ext);
    bus.stall = st; bus.id_redirect = idr; bus.id_target = idt;
    bus.ex_redirect = exr; bus.ex_target = ext;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
`ifdef IF_EXCEPTION_EN
    bus.irq = 1'b0;
`endif
    @(negedge clk);
    // Reset state.
    cyc(mk(32'h0, 32'h0, 32'h0, 0, 32'h0));
    cyc(mk(32'h0, 32'h0, 32'h0, 0, 32'h0));
    reset = 1'b1;
    // Free-running fetch; first capture is the word at 0x0.
    cyc(mk(32'h4,  32'hDEAD0000, 32'h4,  1, 32'h0));
    cyc(mk(32'h8,  32'hDEAD0004, 32'h8,  1, 32'h0));
    cyc(mk(32'hC,  32'hDEAD0008, 32'hC,  1, 32'h0));
    cyc(mk(32'h10, 32'hDEAD000C, 32'h10, 1, 32'h0));
    // Two stall cycles at PC=0x10, then release.
    drive(1, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h10, 32'hDEAD000C, 32'h10, 1, 32'h0));
    cyc(mk(32'h10, 32'hDEAD000C, 32'h10, 1, 32'h0));
    drive(0, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h14, 32'hDEAD0010, 32'h14, 1, 32'h0));
    // id_redirect while stalled is ignored.
    drive(1, 1, 32'h100, 0, 32'h0);
    cyc(mk(32'h14, 32'hDEAD0010, 32'h14, 1, 32'h0));
    drive(0, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h18, 32'hDEAD0014, 32'h18, 1, 32'h0));
    // EX redirect to 0x8, then ID redirect with misaligned target 0xE.
    drive(0, 0, 32'h0, 1, 32'h8);
    cyc(mk(32'h8, 32'h0, 32'h18, 0, 32'h0));
    drive(0, 1, 32'hE, 0, 32'h0);
    cyc(mk(32'hC, 32'h0, 32'h18, 0, 32'h0));
    drive(0, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h10, 32'hDEAD000C, 32'h10, 1, 32'h0));
    // EX, ID and stall together: EX wins.
    drive(1, 1, 32'h80, 1, 32'h40);
    cyc(mk(32'h40, 32'h0, 32'h10, 0, 32'h0));
    drive(0, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h44, 32'hDEAD0040, 32'h44, 1, 32'h0));
    // PC wrap at the top of the address space.
    drive(0, 0, 32'h0, 1, 32'hFFFF_FFFF);
    cyc(mk(32'hFFFF_FFFC, 32'h0, 32'h44, 0, 32'h0));
    drive(0, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h0, 32'h2152_FFFC, 32'h0, 1, 32'h0));
    cyc(mk(32'h4, 32'hDEAD0000, 32'h4, 1, 32'h0));
    // Asynchronous reset mid-stall, sampled between edges.
    drive(1, 0, 32'h0, 0, 32'h0);
    #2;
    reset = 1'b0;
    exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 0, 32'h0));
    -> sample_ev;
    #1;
    exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 0, 32'h0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h4, 32'hDEAD0000, 32'h4, 1, 32'h0));
`ifdef IF_EXCEPTION_EN
    // Place the PC-0x24 instruction in IF/ID, then irq beats stall and EX.
    drive(0, 0, 32'h0, 1, 32'h24);
    cyc(mk(32'h24, 32'h0, 32'h4, 0, 32'h0));
    drive(0, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h28, 32'hDEAD0024, 32'h28, 1, 32'h0));
    drive(1, 1, 32'h80, 1, 32'h40);
    bus.irq = 1'b1;
    cyc(mk(32'h8000_0004, 32'h0, 32'h28, 0, 32'h24));
    // IF/ID now invalid: epc takes the current Address.
    drive(0, 0, 32'h0, 0, 32'h0);
    cyc(mk(32'h8000_0004, 32'h0, 32'h28, 0, 32'h8000_0004));
    bus.irq = 1'b0;
    cyc(mk(32'h8000_0008, 32'h5EAD_0004, 32'h8000_0008, 1, 32'h8000_0004));
`endif
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
